// File: rtl/set_sched_pkg.sv
// set_sched_pkg: shared widths, FSM state encodings and defaults for the SET job scheduler
package set_sched_pkg;
  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W = 12;
  localparam int MODE_W = 2;
  localparam int CAND_W = 8;
  localparam int TIMEOUT_CYC_DEF = 1024;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ISSUE = 3'd1;
  localparam state_t S_WAIT = 3'd2;
  localparam state_t S_RESP = 3'd3;
  localparam state_t S_DRAIN = 3'd4;
endpackage

// File: rtl/set_job_scheduler_if.sv
// set_job_scheduler_if: requester fabric and SET engine signals seen by the scheduler
interface set_job_scheduler_if import set_sched_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IDW = 1
) ();
  logic [NREQ-1:0] req;
  logic [CENTRAL_W*NREQ-1:0] req_central;
  logic [RADIUS_W*NREQ-1:0] req_radius;
  logic [MODE_W*NREQ-1:0] req_mode;
  logic [NREQ-1:0] gnt;
  logic rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [CAND_W-1:0] rsp_candidate;
  logic rsp_timeout;
  logic sched_busy;
  logic eng_en;
  logic [CENTRAL_W-1:0] eng_central;
  logic [RADIUS_W-1:0] eng_radius;
  logic [MODE_W-1:0] eng_mode;
  logic eng_busy;
  logic eng_valid;
  logic [CAND_W-1:0] eng_candidate;
  modport master (
    output req, req_central, req_radius, req_mode, eng_busy, eng_valid, eng_candidate,
    input gnt, rsp_valid, rsp_id, rsp_candidate, rsp_timeout, sched_busy,
    input eng_en, eng_central, eng_radius, eng_mode
  );
  modport slave (
    input req, req_central, req_radius, req_mode, eng_busy, eng_valid, eng_candidate,
    output gnt, rsp_valid, rsp_id, rsp_candidate, rsp_timeout, sched_busy,
    output eng_en, eng_central, eng_radius, eng_mode
  );
endinterface

// File: rtl/set_job_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after the last winner
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);
  logic [IDW-1:0] w_j;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_j = IDW'((int'(i_last) + k) % NREQ);
      if (!o_any && i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/set_job_scheduler.sv
// set_job_scheduler: round-robin sharing of one SET engine with watchdog and drain
module set_job_scheduler import set_sched_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IDW = 1,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TW = 11
) (
  input logic clk,
  input logic rst,
  set_job_scheduler_if.slave bus
);
  state_t r_state, w_next;
  logic [IDW-1:0] r_last, r_id, w_idx;
  logic [CENTRAL_W-1:0] r_central;
  logic [RADIUS_W-1:0] r_radius;
  logic [MODE_W-1:0] r_mode;
  logic [CAND_W-1:0] r_cand;
  logic r_timeout;
  logic [TW-1:0] r_wd;
  logic [NREQ-1:0] w_gnt;
  logic w_any, w_grant, w_tc;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req(bus.req),
    .i_last(r_last),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  // rst gates the grant so nothing is accepted while reset is held
  assign w_grant = rst && r_state == S_IDLE && w_any && !bus.eng_busy;
  assign w_tc = r_wd == TW'(TIMEOUT_CYC - 1);
  always_comb begin
    w_next = r_state == S_IDLE  ? (w_grant ? S_ISSUE : S_IDLE) :
             r_state == S_ISSUE ? S_WAIT :
             r_state == S_WAIT  ? ((bus.eng_valid || w_tc) ? S_RESP : S_WAIT) :
             r_state == S_RESP  ? (r_timeout ? S_DRAIN : S_IDLE) :
             r_state == S_DRAIN ? ((!bus.eng_busy && !bus.eng_valid) ? S_IDLE : S_DRAIN) :
             S_IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_last <= IDW'(NREQ - 1);
      r_id <= '0;
      r_central <= '0;
      r_radius <= '0;
      r_mode <= '0;
      r_cand <= '0;
      r_timeout <= 1'b0;
      r_wd <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_central <= bus.req_central[w_idx*CENTRAL_W +: CENTRAL_W];
        r_radius <= bus.req_radius[w_idx*RADIUS_W +: RADIUS_W];
        r_mode <= bus.req_mode[w_idx*MODE_W +: MODE_W];
        r_id <= w_idx;
        r_last <= w_idx;
      end
      if (r_state == S_ISSUE) r_wd <= '0;
      else if (r_state == S_WAIT && r_wd != '1) r_wd <= r_wd + 1'b1;
      // a result arriving on the terminal-count cycle beats the watchdog
      if (r_state == S_WAIT && bus.eng_valid) begin
        r_cand <= bus.eng_candidate;
        r_timeout <= 1'b0;
      end else if (r_state == S_WAIT && w_tc) begin
        r_cand <= '0;
        r_timeout <= 1'b1;
      end
    end
  end
  assign bus.gnt = w_grant ? w_gnt : '0;
  assign bus.eng_en = r_state == S_ISSUE;
  assign bus.rsp_valid = r_state == S_RESP;
  assign bus.sched_busy = r_state != S_IDLE;
  assign bus.rsp_id = r_id;
  assign bus.rsp_candidate = r_cand;
  assign bus.rsp_timeout = r_timeout;
  assign bus.eng_central = r_central;
  assign bus.eng_radius = r_radius;
  assign bus.eng_mode = r_mode;
endmodule

// File: tb/tb_set_job_scheduler.sv
// tb_set_job_scheduler: directed checks of arbitration, latency, watchdog, drain and reset
module tb_set_job_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  set_job_scheduler_if #(.NREQ(2), .IDW(1)) ifc ();
  set_job_scheduler #(.NREQ(2), .IDW(1), .TIMEOUT_CYC(1024), .TW(11)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int nrsp = 0;
  int nidle = 0;
  int m_cnt = 0;
  int m_lat = 20;
  logic m_busy = 1'b0;
  logic m_valid = 1'b0;
  logic f_busy = 1'b0;
  logic [7:0] m_cand = 8'h00;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive_eng();
    ifc.eng_busy = m_busy | f_busy;
    ifc.eng_valid = m_valid;
    ifc.eng_candidate = m_valid ? m_cand : 8'h00;
    #1;
  endtask
  // engine model: eng_valid m_lat cycles after the eng_en cycle, busy until then
  task automatic tick();
    logic en;
    en = ifc.eng_en;
    @(posedge clk);
    #1;
    cyc++;
    m_valid = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_busy = 1'b0;
      end
    end
    if (en) begin
      m_busy = 1'b1;
      m_cnt = m_lat - 1;
    end
    drive_eng();
  endtask
  initial begin
    #800000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    ifc.req = 2'b00;
    ifc.req_central = {24'hBBBBBB, 24'h444444};
    ifc.req_radius = {12'h222, 12'h333};
    ifc.req_mode = {2'd2, 2'd0};
    drive_eng();
    ifc.req = 2'b01;
    tick();
    tick();
    chk("rst_gnt", 32'(ifc.gnt), 0);
    chk("rst_flags", 32'({ifc.sched_busy, ifc.eng_en, ifc.rsp_valid, ifc.rsp_timeout}), 0);
    chk("rst_rsp", 32'({ifc.rsp_id, ifc.rsp_candidate}), 0);
    chk("rst_ops", 32'(ifc.eng_central), 0);
    chk("rst_ops2", 32'({ifc.eng_radius, ifc.eng_mode}), 0);
    // single job
    m_lat = 20;
    m_cand = 8'h1D;
    rst = 1'b1;
    #1;
    chk("t1_gnt", 32'(ifc.gnt), 1);
    tick();
    ifc.req = 2'b00;
    #1;
    chk("t1_en", 32'(ifc.eng_en), 1);
    chk("t1_gnt_pulse", 32'(ifc.gnt), 0);
    chk("t1_central", 32'(ifc.eng_central), 32'h444444);
    chk("t1_radius", 32'(ifc.eng_radius), 32'h333);
    chk("t1_busy", 32'(ifc.sched_busy), 1);
    tick();
    chk("t1_en_off", 32'(ifc.eng_en), 0);
    for (int i = 0; i < 40 && !ifc.eng_valid; i++) tick();
    chk("t1_engvalid", 32'(ifc.eng_valid), 1);
    chk("t1_noearly", 32'(ifc.rsp_valid), 0);
    t0 = cyc;
    tick();
    chk("t1_rsp", 32'(ifc.rsp_valid), 1);
    chk("t1_lat", cyc - t0, 1);
    chk("t1_id", 32'(ifc.rsp_id), 0);
    chk("t1_cand", 32'(ifc.rsp_candidate), 32'h1D);
    chk("t1_to", 32'(ifc.rsp_timeout), 0);
    tick();
    chk("t1_idle", 32'({ifc.sched_busy, ifc.rsp_valid}), 0);
    // fairness from a fresh reset
    rst = 1'b0;
    #1;
    rst = 1'b1;
    ifc.req = 2'b11;
    #1;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 5 && ifc.gnt == 2'b00; i++) tick();
      chk("fair_gnt", 32'(ifc.gnt), 1 << (j % 2));
      m_cand = 8'h10 + 8'(j);
      tick();
      chk("fair_op", 32'(ifc.eng_central), (j % 2) ? 32'hBBBBBB : 32'h444444);
      for (int i = 0; i < 40 && !ifc.rsp_valid; i++) tick();
      chk("fair_rsp", 32'({ifc.rsp_valid, ifc.rsp_id}), 2 + (j % 2));
      chk("fair_cand", 32'(ifc.rsp_candidate), 32'h10 + j);
      if (j == 3) begin
        ifc.req = 2'b10;
        f_busy = 1'b1;
        drive_eng();
      end
      tick();
    end
    // engine busy blocks grants
    chk("blk_nognt", 32'(ifc.gnt), 0);
    tick();
    tick();
    chk("blk_nognt2", 32'({ifc.gnt, ifc.sched_busy}), 0);
    f_busy = 1'b0;
    drive_eng();
    chk("blk_gnt", 32'(ifc.gnt), 2);
    m_cand = 8'h77;
    tick();
    ifc.req = 2'b00;
    #1;
    for (int i = 0; i < 40 && !ifc.rsp_valid; i++) tick();
    chk("blk_rsp", 32'({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_candidate}), 32'h377);
    tick();
    // watchdog timeout then drain
    m_lat = 1500;
    m_cand = 8'h55;
    ifc.req = 2'b01;
    #1;
    chk("to_gnt", 32'(ifc.gnt), 1);
    tick();
    t0 = cyc;
    ifc.req = 2'b00;
    #1;
    for (int i = 0; i < 1100 && !ifc.rsp_valid; i++) tick();
    chk("to_at", cyc - t0, 1025);
    chk("to_rsp", 32'({ifc.rsp_valid, ifc.rsp_timeout, ifc.rsp_id}), 32'b110);
    chk("to_cand", 32'(ifc.rsp_candidate), 0);
    nrsp = 0;
    nidle = 0;
    for (int i = 0; i < 600 && !ifc.eng_valid; i++) begin
      tick();
      nrsp += int'(ifc.rsp_valid);
      nidle += int'(!ifc.sched_busy);
    end
    chk("drain_late_valid", 32'(ifc.eng_valid), 1);
    chk("drain_busy", 32'(ifc.sched_busy), 1);
    tick();
    nrsp += int'(ifc.rsp_valid);
    chk("drain_hold", 32'(ifc.sched_busy), 1);
    tick();
    nrsp += int'(ifc.rsp_valid);
    chk("drain_idle", 32'(ifc.sched_busy), 0);
    chk("drain_norsp", nrsp, 0);
    chk("drain_stayed", nidle, 0);
    // eng_valid on the terminal-count cycle
    m_lat = 1024;
    m_cand = 8'h66;
    ifc.req = 2'b10;
    #1;
    chk("tie_gnt", 32'(ifc.gnt), 2);
    tick();
    t0 = cyc;
    ifc.req = 2'b00;
    #1;
    for (int i = 0; i < 1100 && !ifc.rsp_valid; i++) tick();
    chk("tie_at", cyc - t0, 1025);
    chk("tie_rsp", 32'({ifc.rsp_valid, ifc.rsp_timeout, ifc.rsp_id}), 32'b101);
    chk("tie_cand", 32'(ifc.rsp_candidate), 32'h66);
    tick();
    chk("tie_idle", 32'(ifc.sched_busy), 0);
    // reset in the middle of WAIT
    m_lat = 50;
    ifc.req = 2'b01;
    #1;
    tick();
    ifc.req = 2'b00;
    #1;
    tick();
    tick();
    chk("mid_busy", 32'(ifc.sched_busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_flags", 32'({ifc.sched_busy, ifc.eng_en, ifc.rsp_valid, ifc.rsp_timeout, ifc.gnt}), 0);
    chk("mid_rsp", 32'({ifc.rsp_id, ifc.rsp_candidate}), 0);
    chk("mid_ops", 32'(ifc.eng_central), 0);
    ifc.req = 2'b11;
    #1;
    chk("mid_rst_nognt", 32'(ifc.gnt), 0);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_engbusy_nognt", 32'(ifc.gnt), 0);
    for (int i = 0; i < 60 && ifc.gnt == 2'b00; i++) tick();
    chk("mid_rr0", 32'(ifc.gnt), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/set_job_scheduler.md
Name: set_job_scheduler

Overview:
- Shares one SET candidate-counting engine among NREQ requesters using round-robin arbitration.
- Per job: latches the winner's operands, pulses the engine start, waits for the engine's valid, and returns the candidate count tagged with the requester id.
- A watchdog terminates jobs the engine never completes and drains the engine before the next issue.
- Sits between the requester fabric and the single SET instance.

Parameters:
NREQ, 2, number of requesters (2..4)
IDW, 1, width of requester id (clog2 NREQ, min 1)
TIMEOUT_CYC, 1024, max cycles in WAIT before timeout (engine worst case ~850)
TW, 11, watchdog counter width (must hold TIMEOUT_CYC)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (all state cleared while rst==0)
req  in  NREQ  per-requester job request; held with operands until granted
req_central  in  24*NREQ  packed {XA,YA,XB,YB,XC,YC} nibbles, slice i for requester i
req_radius  in  12*NREQ  packed {RA,RB,RC}, slice i
req_mode  in  2*NREQ  set-operation mode, slice i
gnt  out  NREQ  one-hot accept pulse, one cycle
rsp_valid  out  1  result pulse, one cycle
rsp_id  out  IDW  requester index of result
rsp_candidate  out  8  candidate count (0 on timeout)
rsp_timeout  out  1  qualifies rsp_valid: job aborted by watchdog
sched_busy  out  1  high whenever state != IDLE
eng_en  out  1  engine start pulse
eng_central  out  24  latched operand
eng_radius  out  12  latched operand
eng_mode  out  2  latched operand
eng_busy  in  1  engine busy
eng_valid  in  1  engine result pulse
eng_candidate  in  8  engine result, valid with eng_valid

Behaviour:
- Reset (rst==0, async): state=IDLE; gnt, eng_en, rsp_valid, rsp_timeout, sched_busy = 0; rsp_id, rsp_candidate, eng_* operands = 0; RR pointer last=NREQ-1, so requester 0 has highest priority first.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - If |req and eng_busy==0, the winner is the first set req[i] scanning from last+1 cyclically.
  - gnt[winner] is asserted combinationally in that cycle.
  - At the edge: latch winner's central/radius/mode/id, set last=winner, go ISSUE.
  - If eng_busy==1, no grant is made.
- ISSUE: eng_en=1 for exactly one cycle with latched operands; clear watchdog; go WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On eng_valid: capture eng_candidate into rsp_candidate, rsp_timeout=0, go RESP.
  - Else, when watchdog==TIMEOUT_CYC-1: rsp_candidate=0, rsp_timeout=1, go RESP, then DRAIN.
  - If eng_valid and terminal count occur in the same cycle, eng_valid wins.
- RESP: rsp_valid=1 and rsp_id held for one cycle. Next state is IDLE on a normal job, DRAIN on a timeout.
- DRAIN: wait until eng_busy==0 and eng_valid==0, then IDLE. An eng_valid arriving in DRAIN is discarded (no rsp).
- Latency: gnt at cycle T, eng_en at T+1, rsp_valid one cycle after eng_valid. Minimum turnaround back to IDLE is eng_valid+2.
- Operand outputs hold their value from latch until the next grant.
- Requests are never dropped. A non-granted req keeps waiting, and the RR pointer guarantees service within NREQ jobs.
- A requester deasserting req before grant is legal and is simply not served.
- Reset mid-job aborts with no rsp. The engine is not reset by this block, so the first post-reset grant still waits for eng_busy==0.
- Widths: watchdog is TW bits and saturates (never wraps). The RR pointer is IDW bits and wraps at NREQ-1→0.

Decomposition:
- Package set_sched_pkg: state enum; widths CENTRAL_W=24, RADIUS_W=12, MODE_W=2, CAND_W=8; default TIMEOUT_CYC.
- Sub-module rr_arbiter (NREQ): req vector and last pointer in, one-hot winner and winner index out, purely combinational.
- The scheduler owns the FSM, latches and watchdog.

Test Plan:
- Single job: req[0]=1, central=0x444444, radius=0x333, mode=0 with SET attached → gnt[0] one cycle, eng_en next cycle, rsp_valid with rsp_id=0, rsp_candidate=0x1D (29), rsp_timeout=0.
- Fairness: req=2'b11 held for 4 jobs with a fixed-latency engine model (valid 20 cycles after en) → grant order 0,1,0,1 and rsp_id matches each.
- Busy blocking: eng_busy forced 1 in IDLE with req[1]=1 → no gnt; release eng_busy → gnt[1] the same cycle.
- Timeout: model never asserts eng_valid, keeps busy 1 for 1500 cycles → rsp_valid at exactly TIMEOUT_CYC cycles after WAIT entry with rsp_timeout=1, candidate=0; sched_busy stays 1 until busy drops; a late eng_valid produces no rsp.
- Valid/timeout tie: eng_valid on the terminal-count cycle → rsp_timeout=0, candidate captured, next state IDLE.
- Reset mid-WAIT: pull rst low → all outputs 0 asynchronously; after release, pending req[1] and req[0] → requester 0 granted first.
